// File: rtl/gen_wave.sv
// Direct digital synthesis waveform generator: phase accumulator with
// period-boundary shadowed settings, producing triangle/saw/square samples.
module gen_wave #(
    parameter int OUT_W = 24,
    parameter int ACC_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             restart,
    input  logic [1:0]       mode,
    input  logic [ACC_W-1:0] phase_inc,
    input  logic [7:0]       duty,
    output logic [OUT_W-1:0] out,
    output logic             sync
);

    localparam logic [1:0] MODE_TRI = 2'd0;
    localparam logic [1:0] MODE_SAW = 2'd1;
    localparam logic [1:0] MODE_SQR = 2'd2;
    localparam logic [1:0] MODE_OFF = 2'd3;

    // Upper half of the ramp is mirrored so the peak lands at half phase.
    function automatic logic [OUT_W-1:0] tri_fold(input logic [OUT_W:0] p);
        return p[OUT_W] ? ~p[OUT_W-1:0] : p[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] square_level(input logic [7:0] top,
                                                      input logic [7:0] d);
        return (top < d) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    endfunction

    logic [ACC_W-1:0] phase_p0;
    logic             sync_p0;
    logic [ACC_W-1:0] inc_q;
    logic [1:0]       mode_q;
    logic [7:0]       duty_q;
    logic [OUT_W-1:0] out_p1;
    logic             sync_p1;

    logic [ACC_W:0]   sum;
    logic             wrap;
    logic             load;
    logic [OUT_W-1:0] wave;

    assign sum  = {1'b0, phase_p0} + {1'b0, inc_q};
    assign wrap = en & ~restart & sum[ACC_W];
    // A zero step never wraps, so settings must be allowed in directly.
    assign load = wrap | restart | ~en | (inc_q == '0);

    always_comb begin
        wave = '0;
        case (mode_q)
            MODE_TRI: wave = tri_fold(phase_p0[ACC_W-1 -: OUT_W+1]);
            MODE_SAW: wave = phase_p0[ACC_W-1 -: OUT_W];
            MODE_SQR: wave = square_level(phase_p0[ACC_W-1 -: 8], duty_q);
            MODE_OFF: wave = '0;
            default:  wave = '0;
        endcase
    end

    // Stage p0: phase accumulator; sync_p0 marks a phase that opens a period.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            phase_p0 <= '0;
            sync_p0  <= 1'b0;
        end else if (restart) begin
            phase_p0 <= '0;
            sync_p0  <= 1'b1;
        end else if (en) begin
            phase_p0 <= sum[ACC_W-1:0];
            sync_p0  <= sum[ACC_W];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            inc_q  <= '0;
            mode_q <= '0;
            duty_q <= '0;
        end else if (load) begin
            inc_q  <= phase_inc;
            mode_q <= mode;
            duty_q <= duty;
        end
    end

    // Stage p1: registered sample; a pending period start waits out en=0.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_p1  <= '0;
            sync_p1 <= 1'b0;
        end else if (en) begin
            out_p1  <= wave;
            sync_p1 <= sync_p0;
        end else begin
            sync_p1 <= 1'b0;
        end
    end

    assign out  = out_p1;
    assign sync = sync_p1;

endmodule

// File: tb/tb_gen_wave.sv
// Testbench for gen_wave: vector table, hand-written corner sequences and
// randomized stimulus against a behavioural model.
module tb_gen_wave;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en = 1'b0;
    logic        restart = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] phase_inc = 32'h0;
    logic [7:0]  duty = 8'h0;
    logic [23:0] out;
    logic        sync;

    int total = 0;
    int bad = 0;

    gen_wave #(.OUT_W(24), .ACC_W(32)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .en(en),
        .restart(restart),
        .mode(mode),
        .phase_inc(phase_inc),
        .duty(duty),
        .out(out),
        .sync(sync)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model state
    logic [31:0] m_phase = 32'h0;
    logic [31:0] m_inc = 32'h0;
    logic [1:0]  m_mode = 2'd0;
    logic [7:0]  m_duty = 8'h0;
    bit          m_start = 1'b0;
    logic [23:0] m_out = 24'h0;
    bit          m_sync = 1'b0;

    function automatic logic [23:0] ref_wave(logic [31:0] ph, logic [1:0] md, logic [7:0] d);
        int unsigned p;
        case (md)
            2'd0: begin
                p = ph / 128;
                if (p < 32'h100_0000) return 24'(p);
                return 24'(32'h1FF_FFFF - p);
            end
            2'd1: return 24'(ph / 256);
            2'd2: return ((ph / 32'h100_0000) < 32'(d)) ? 24'hFFFFFF : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_phase = 0; m_inc = 0; m_mode = 0; m_duty = 0;
        m_start = 0; m_out = 0; m_sync = 0;
    endtask

    task automatic model_step();
        logic [63:0] s;
        bit          wr;
        logic [31:0] nph;
        bit          nst;
        if (sys_rst) begin
            model_clear();
            return;
        end
        wr = 0; nph = m_phase; nst = m_start;
        if (restart) begin
            nph = 0; nst = 1;
        end else if (en) begin
            s = {32'h0, m_phase} + {32'h0, m_inc};
            wr = (s >= 64'h1_0000_0000);
            nph = s[31:0];
            nst = wr;
        end
        if (en) begin
            m_out = ref_wave(m_phase, m_mode, m_duty);
            m_sync = m_start;
        end else begin
            m_sync = 0;
        end
        if (restart || !en || m_inc == 0 || wr) begin
            m_inc = phase_inc; m_mode = mode; m_duty = duty;
        end
        m_phase = nph;
        m_start = nst;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          en;
        bit          restart;
        logic [1:0]  mode;
        logic [31:0] inc;
        logic [7:0]  duty;
        bit          chk;
        logic [23:0] exp_out;
        bit          exp_sync;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_block(logic [1:0] md, logic [7:0] d);
        vec_t v;
        int   i;
        v = '{en: 1, restart: 1, mode: md, inc: 32'h1000_0000, duty: d,
              chk: 0, exp_out: 0, exp_sync: 0};
        vecs.push_back(v);
        for (int j = 0; j < 17; j++) begin
            i = j % 16;
            v.restart = 0;
            v.chk = 1;
            v.exp_sync = (i == 0);
            case (md)
                2'd0: v.exp_out = (i < 8) ? 24'(i * 32'h20_0000)
                                          : 24'(32'hFF_FFFF - (i - 8) * 32'h20_0000);
                2'd1: v.exp_out = 24'(i * 32'h10_0000);
                2'd2: v.exp_out = (i < (int'(d) + 15) / 16) ? 24'hFFFFFF : 24'h0;
                default: v.exp_out = 24'h0;
            endcase
            vecs.push_back(v);
        end
    endfunction

    initial begin
        add_block(2'd1, 8'd0);
        add_block(2'd0, 8'd0);
        add_block(2'd2, 8'd128);
        add_block(2'd2, 8'd0);
        add_block(2'd2, 8'd255);
        add_block(2'd3, 8'd0);

        // Reset state, then release with settings applied but no restart
        en = 1; mode = 2'd1; phase_inc = 32'h1000_0000;
        tick(); tick();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_sync", 32'(sync), 32'h0);
        #2 sys_rst = 0;
        tick();
        chk("rel1_out", 32'(out), 32'h0);
        chk("rel1_sync", 32'(sync), 32'h0);
        tick();
        chk("rel2_out", 32'(out), 32'h0);
        chk("rel2_sync", 32'(sync), 32'h0);
        tick();
        chk("rel3_out", 32'(out), 32'h10_0000);
        chk("rel3_sync", 32'(sync), 32'h0);

        // Table-driven waveform vectors
        for (int k = 0; k < vecs.size(); k++) begin
            en = vecs[k].en; restart = vecs[k].restart; mode = vecs[k].mode;
            phase_inc = vecs[k].inc; duty = vecs[k].duty;
            tick();
            if (vecs[k].chk) begin
                chk("tbl_out", 32'(out), 32'(vecs[k].exp_out));
                chk("tbl_sync", 32'(sync), 32'(vecs[k].exp_sync));
            end
        end

        // Deferred increment change at cycle 5 of a period
        en = 1; restart = 1; mode = 2'd1; phase_inc = 32'h1000_0000;
        tick();
        restart = 0;
        for (int j = 1; j <= 16; j++) begin
            if (j == 6) phase_inc = 32'h2000_0000;
            tick();
            chk("dfr_old_out", 32'(out), (j - 1) * 32'h10_0000);
            chk("dfr_old_sync", 32'(sync), 32'(j == 1));
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("dfr_new_out", 32'(out), (k % 8) * 32'h20_0000);
            chk("dfr_new_sync", 32'(sync), 32'(k % 8 == 0));
        end

        // Hold and resume
        restart = 1; phase_inc = 32'h1000_0000;
        tick();
        restart = 0;
        for (int j = 1; j <= 6; j++) tick();
        chk("hold_pre_out", 32'(out), 32'h50_0000);
        en = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("hold_out", 32'(out), 32'h50_0000);
            chk("hold_sync", 32'(sync), 32'h0);
        end
        en = 1;
        for (int j = 6; j <= 16; j++) begin
            tick();
            chk("resume_out", 32'(out), (j % 16) * 32'h10_0000);
            chk("resume_sync", 32'(sync), 32'(j == 16));
        end

        // Zero increment: phase and sample stay put
        restart = 1; phase_inc = 32'h0;
        tick();
        restart = 0;
        tick();
        chk("zinc_first_sync", 32'(sync), 32'h1);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("zinc_out", 32'(out), 32'h0);
            chk("zinc_sync", 32'(sync), 32'h0);
        end
        phase_inc = 32'h1000_0000;
        tick(); tick(); tick();
        chk("zinc_start_out", 32'(out), 32'h10_0000);
        chk("zinc_start_sync", 32'(sync), 32'h0);

        // Asynchronous reset mid-period, released together with restart
        tick(); tick();
        #2 sys_rst = 1;
        model_clear();
        #1;
        chk("arst_out", 32'(out), 32'h0);
        chk("arst_sync", 32'(sync), 32'h0);
        tick(); tick();
        sys_rst = 0; restart = 1; en = 1; mode = 2'd1; phase_inc = 32'h1000_0000;
        tick();
        chk("arst_rel_sync", 32'(sync), 32'h0);
        restart = 0;
        for (int j = 0; j < 17; j++) begin
            tick();
            chk("arst_saw_out", 32'(out), (j % 16) * 32'h10_0000);
            chk("arst_saw_sync", 32'(sync), 32'(j % 16 == 0));
        end

        // Randomized stimulus against the model
        for (int n = 0; n < 2000; n++) begin
            en = ($urandom_range(0, 99) >= 12);
            restart = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) begin
                mode = 2'($urandom_range(0, 3));
                duty = 8'($urandom);
                case ($urandom_range(0, 3))
                    0: phase_inc = 32'h0;
                    1: phase_inc = 32'h1 << $urandom_range(22, 31);
                    2: phase_inc = $urandom;
                    default: phase_inc = 32'h1000_0000;
                endcase
            end
            tick();
            chk("rnd_out", 32'(out), 32'(m_out));
            chk("rnd_sync", 32'(sync), 32'(m_sync));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
